// File: rtl/downlink_pie_decoder.sv
// PIE downlink decoder: measures envelope level widths and turns each
// high/low symbol into a decoded bit, with frame start/end/error flags.
module downlink_pie_decoder #(
   parameter int CNT_W     = 8,
   parameter int PW_MAX    = 8,
   parameter int DELIM_MIN = 10,
   parameter int DELIM_MAX = 20,
   parameter int HIGH_MIN  = 4,
   parameter int THRESH    = 18,
   parameter int HIGH_MAX  = 40,
   parameter int TIMEOUT   = 100
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       downlink_in,
   output logic       write_en,
   output logic       downlink_bit,
   output logic       frame_active,
   output logic       frame_done,
   output logic       frame_err,
   output logic [7:0] bit_count
);

   typedef enum logic {S_IDLE, S_DATA} state_t;

   localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);
   localparam logic [CNT_W-1:0] SAT_C   = '1;
   localparam logic [CNT_W-1:0] PW_C    = CNT_W'(PW_MAX);
   localparam logic [CNT_W-1:0] DMIN_C  = CNT_W'(DELIM_MIN);
   localparam logic [CNT_W-1:0] DMAX_C  = CNT_W'(DELIM_MAX);
   localparam logic [CNT_W-1:0] LOWL_C  = CNT_W'(DELIM_MAX + 1);
   localparam logic [CNT_W-1:0] HMIN_C  = CNT_W'(HIGH_MIN);
   localparam logic [CNT_W-1:0] THR_C   = CNT_W'(THRESH);
   localparam logic [CNT_W-1:0] HMAX_C  = CNT_W'(HIGH_MAX);
   localparam logic [CNT_W-1:0] TOUT_C  = CNT_W'(TIMEOUT);

   logic             sync1_q, sync2_q, prev_q;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   state_t           state_q, state_d;
   logic             we_q, we_d;
   logic             bit_q, bit_d;
   logic             done_q, done_d;
   logic             err_q, err_d;
   logic [7:0]       bcnt_q, bcnt_d;

   logic             edge_w, rise, fall, is_delim;
   logic             emit, emit_val, fault, tout, start;

   assign edge_w   = sync2_q != prev_q;
   assign rise     = edge_w & sync2_q;
   assign fall     = edge_w & ~sync2_q;
   assign is_delim = (cnt_q >= DMIN_C) && (cnt_q <= DMAX_C);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         prev_q  <= 1'b1;
         cnt_q   <= '0;
         state_q <= S_IDLE;
         we_q    <= 1'b0;
         bit_q   <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         bcnt_q  <= '0;
      end else begin
         sync1_q <= downlink_in;
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
         cnt_q   <= cnt_d;
         state_q <= state_d;
         we_q    <= we_d;
         bit_q   <= bit_d;
         done_q  <= done_d;
         err_q   <= err_d;
         bcnt_q  <= bcnt_d;
      end
   end

   // On an edge cnt_q still holds the width of the level that just ended.
   always_comb begin
      cnt_d = cnt_q;
      if (edge_w)
         cnt_d = ONE_C;
      else if (cnt_q != SAT_C)
         cnt_d = cnt_q + ONE_C;
   end

   always_comb begin
      state_d  = state_q;
      emit     = 1'b0;
      emit_val = 1'b0;
      fault    = 1'b0;
      tout     = 1'b0;
      start    = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (rise && is_delim) begin
               state_d = S_DATA;
               start   = 1'b1;
            end
         end
         S_DATA: begin
            if (rise) begin
               if (cnt_q > PW_C) begin
                  if (is_delim)
                     start = 1'b1;
                  else
                     fault = 1'b1;
               end
            end else if (fall) begin
               if (cnt_q < HMIN_C)
                  fault = 1'b1;
               else if (cnt_q <= THR_C)
                  emit = 1'b1;
               else if (cnt_q <= HMAX_C) begin
                  emit     = 1'b1;
                  emit_val = 1'b1;
               end else
                  fault = 1'b1;
            end else if (!prev_q && cnt_d == LOWL_C)
               fault = 1'b1;
            else if (prev_q && cnt_d == TOUT_C)
               tout = 1'b1;
            if (fault || tout)
               state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      we_d   = emit;
      bit_d  = emit ? emit_val : bit_q;
      err_d  = fault;
      done_d = tout && (bcnt_q != 8'd0);
      bcnt_d = bcnt_q;
      if (start)
         bcnt_d = 8'd0;
      else if (emit && bcnt_q != 8'hFF)
         bcnt_d = bcnt_q + 8'd1;
   end

   assign write_en     = we_q;
   assign downlink_bit = bit_q;
   assign frame_active = (state_q == S_DATA);
   assign frame_done   = done_q;
   assign frame_err    = err_q;
   assign bit_count    = bcnt_q;

endmodule
